// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronised rx line, mid-bit sampling, level valid/ack
// delivery with one-cycle frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned HALF      = CLK_PER_BIT / 2;
    localparam logic [7:0]  HALF_LAST = 8'(HALF - 1);
    localparam logic [7:0]  BIT_LAST  = 8'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] sync_q;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       busy_q, busy_d;
    logic       rx_s;

    assign rx_s       = sync_q[1];
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

    // State and datapath registers; sync flops reset to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sync_q    <= 2'b11;
            clk_cnt_q <= 8'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rx};
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, counters, shift register and handshake
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (data_ack && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    clk_cnt_d = 8'd0;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = 8'd0;
                    bit_cnt_d = 3'd0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    clk_cnt_d = 8'd0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 8'd0;
                    if (rx_s) begin
                        // An ack landing on the delivery edge suppresses overrun
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !data_ack;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: the bench drives serial frames itself and checks
// delivery timing, handshake, glitch rejection, framing error, overrun and reset.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_chk;
    int n_pass;

    int         cyc;
    int         fe_cnt;
    int         ov_cnt;
    int         both_cnt;
    int         busy_hi;
    int         busy_lo;
    int         dv_hi;
    logic [7:0] got;
    logic       dv154;
    logic       dv155;

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_ack  (data_ack),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        cyc      = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        both_cnt = 0;
        busy_hi  = 0;
        busy_lo  = 0;
        dv_hi    = 0;
        got      = 8'hxx;
        dv154    = 1'bx;
        dv155    = 1'bx;
    endtask

    // One clock; observes outputs on the falling edge after posedge number cyc
    task automatic tick();
        @(negedge clk);
        cyc++;
        fe_cnt   += int'(frame_err);
        ov_cnt   += int'(overrun);
        both_cnt += int'(frame_err && overrun);
        busy_hi  += int'(busy);
        busy_lo  += int'(!busy);
        dv_hi    += int'(data_valid);
        if (cyc == 154) dv154 = data_valid;
        if (cyc == 155) begin
            got   = data_out;
            dv155 = data_valid;
        end
    endtask

    task automatic idle(input logic v, input int n);
        rx = v;
        repeat (n) tick();
    endtask

    // ack_at > 0 raises data_ack so that it is sampled on posedge ack_at+1
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int ack_at);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < int'(CPB); c++) begin
                data_ack = (ack_at > 0) && (cyc == ack_at);
                tick();
            end
        end
        data_ack = 1'b0;
    endtask

    task automatic do_ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] b3 [3];
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        rx       = 1'b1;
        data_ack = 1'b0;
        clear_mon();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(1'b1, 5);

        // Single byte: valid first high after edge 155
        clear_mon();
        send_frame(8'hA5, 1'b1, 0);
        chk("a5_valid_e154", 32'(dv154), 32'd0);
        chk("a5_valid_e155", 32'(dv155), 32'd1);
        chk("a5_data", 32'(got), 32'hA5);
        chk("a5_ferr", 32'(fe_cnt), 32'd0);
        chk("a5_ovr", 32'(ov_cnt), 32'd0);
        chk("a5_busy_low", 32'(busy_lo), 32'd8);
        idle(1'b1, 3);
        chk("a5_valid_hold", 32'(data_valid), 32'd1);
        do_ack();
        chk("a5_ack_clears", 32'(data_valid), 32'd0);
        do_ack();
        chk("ack_idle_valid", 32'(data_valid), 32'd0);
        chk("ack_idle_data", 32'(data_out), 32'hA5);

        // Back-to-back frames, each acked 3 cycles after delivery
        b3[0] = 8'h00;
        b3[1] = 8'hFF;
        b3[2] = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            send_frame(b3[k], 1'b1, 157);
            chk($sformatf("b2b%0d_data", k), 32'(got), 32'(b3[k]));
            chk($sformatf("b2b%0d_valid", k), 32'(dv155), 32'd1);
            chk($sformatf("b2b%0d_errs", k), 32'(fe_cnt + ov_cnt), 32'd0);
            chk($sformatf("b2b%0d_busy_low", k), 32'(busy_lo), 32'd8);
        end
        chk("b2b_acked", 32'(data_valid), 32'd0);

        // Start glitch: 5 low cycles, rejected at mid start bit
        clear_mon();
        idle(1'b0, 5);
        idle(1'b1, 30);
        chk("glitch_busy_cycles", 32'(busy_hi), 32'd8);
        chk("glitch_ferr", 32'(fe_cnt), 32'd0);
        chk("glitch_valid", 32'(dv_hi), 32'd0);
        chk("glitch_busy_end", 32'(busy), 32'd0);

        // Framing error followed by a held-low line
        clear_mon();
        send_frame(8'h81, 1'b0, 0);
        idle(1'b0, 40);
        chk("brk_ferr_once", 32'(fe_cnt), 32'd1);
        chk("brk_no_overlap", 32'(both_cnt), 32'd0);
        chk("brk_valid", 32'(dv_hi), 32'd0);
        chk("brk_data_kept", 32'(data_out), 32'h3C);
        chk("brk_busy_cycles", 32'(busy_hi), 32'd198);
        clear_mon();
        idle(1'b1, 10);
        chk("brk_release_busy", 32'(busy_hi), 32'd2);
        chk("brk_release_ferr", 32'(fe_cnt), 32'd0);

        // Overrun: two bytes without ack
        clear_mon();
        send_frame(8'h11, 1'b1, 0);
        chk("ovr_first_data", 32'(got), 32'h11);
        chk("ovr_first_none", 32'(ov_cnt), 32'd0);
        clear_mon();
        send_frame(8'h22, 1'b1, 0);
        chk("ovr_pulse_once", 32'(ov_cnt), 32'd1);
        chk("ovr_no_overlap", 32'(both_cnt), 32'd0);
        chk("ovr_data", 32'(got), 32'h22);
        chk("ovr_valid_before", 32'(dv154), 32'd1);
        chk("ovr_valid_after", 32'(dv155), 32'd1);

        // Ack on the delivery edge: new byte loaded, no overrun
        clear_mon();
        send_frame(8'h44, 1'b1, 154);
        chk("ackdel_ovr", 32'(ov_cnt), 32'd0);
        chk("ackdel_data", 32'(got), 32'h44);
        chk("ackdel_valid", 32'(dv155), 32'd1);
        idle(1'b1, 4);
        chk("ackdel_valid_hold", 32'(data_valid), 32'd1);

        // Reset in the middle of data bit 4
        clear_mon();
        idle(1'b0, int'(CPB) * 5 + 8);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_flags", 32'({frame_err, overrun}), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, 5);
        clear_mon();
        send_frame(8'h5A, 1'b1, 0);
        chk("post_rst_data", 32'(got), 32'h5A);
        chk("post_rst_valid_e154", 32'(dv154), 32'd0);
        chk("post_rst_valid_e155", 32'(dv155), 32'd1);
        chk("post_rst_errs", 32'(fe_cnt + ov_cnt), 32'd0);
        idle(1'b1, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
